// File: rtl/sf_camera_dma_pkg.sv
// Shared types and helpers for the camera frame DMA write master.
// SF_CAMERA_DMA_BYTE_SWAP_EN (in the top) selects byte_swap32 on the load path.
package sf_camera_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BLK,
    ST_ACTIVATE,
    ST_LOAD,
    ST_WRITE,
    ST_POP,
    ST_RELEASE
  } dma_state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Big-endian pixel packing to little-endian memory image.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sf_camera_frame_dma.sv
// Drains camera ping-pong FIFO blocks into consecutive memory words, one frame at a time.
// Define SF_CAMERA_DMA_BYTE_SWAP_EN to byte-swap each word as it is loaded.
module sf_camera_frame_dma
  import sf_camera_dma_pkg::*;
#(
  parameter int unsigned ADDR_INC    = WORD_BYTES,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [31:0] i_base_addr,
  input  logic [23:0] i_frame_words,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [31:0] o_frame_count,
  output logic        o_error,
  input  logic        i_rfifo_ready,
  output logic        o_rfifo_activate,
  output logic        o_rfifo_strobe,
  input  logic [31:0] i_rfifo_data,
  input  logic [23:0] i_rfifo_size,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  input  logic        i_mem_ack
);

  localparam logic [31:0] INC     = 32'(ADDR_INC);
  localparam logic [31:0] TMO_MAX = 32'(ACK_TIMEOUT);

  dma_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] fcount_q, fcount_d;
  logic [31:0] tmo_q, tmo_d;
  logic [23:0] word_q, word_d;
  logic [23:0] blk_q, blk_d;
  logic        we_q, we_d;
  logic        strobe_q, strobe_d;
  logic        act_q, act_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        ack_hit;
  logic        timeout_hit;
  logic [23:0] word_next;
  logic        frame_end;
  logic [31:0] load_word;

  assign ack_hit     = (state_q == ST_WRITE) && i_mem_ack;
  assign timeout_hit = (state_q == ST_WRITE) && !i_mem_ack && (tmo_q == TMO_MAX);
  assign word_next   = word_q + 24'd1;
  assign frame_end   = (word_next == i_frame_words);

`ifdef SF_CAMERA_DMA_BYTE_SWAP_EN
  assign load_word = byte_swap32(i_rfifo_data);
`else
  assign load_word = i_rfifo_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      fcount_q <= '0;
      tmo_q    <= '0;
      word_q   <= '0;
      blk_q    <= '0;
      we_q     <= 1'b0;
      strobe_q <= 1'b0;
      act_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      fcount_q <= fcount_d;
      tmo_q    <= tmo_d;
      word_q   <= word_d;
      blk_q    <= blk_d;
      we_q     <= we_d;
      strobe_q <= strobe_d;
      act_q    <= act_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (i_enable && (i_frame_words != '0)) state_d = ST_WAIT_BLK;
      ST_WAIT_BLK: begin
        if (!i_enable)          state_d = ST_IDLE;
        else if (i_rfifo_ready) state_d = ST_ACTIVATE;
      end
      ST_ACTIVATE: state_d = (blk_q == '0) ? ST_RELEASE : ST_LOAD;
      ST_LOAD:     state_d = ST_WRITE;
      ST_WRITE: begin
        if (ack_hit)          state_d = ST_POP;
        else if (timeout_hit) state_d = ST_RELEASE;
      end
      ST_POP:      state_d = ((blk_q == '0) || !i_enable) ? ST_RELEASE : ST_LOAD;
      ST_RELEASE:  state_d = i_enable ? ST_WAIT_BLK : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    fcount_d = fcount_q;
    tmo_d    = tmo_q;
    word_d   = word_q;
    blk_d    = blk_q;
    we_d     = we_q;
    act_d    = act_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;

    if (!i_enable)        err_d = 1'b0;
    else if (timeout_hit) err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (state_d == ST_WAIT_BLK) begin
          addr_d = i_base_addr;
          word_d = '0;
        end
      end
      ST_WAIT_BLK: begin
        if (state_d == ST_ACTIVATE) begin
          blk_d = i_rfifo_size;
          act_d = 1'b1;
        end
      end
      ST_LOAD: begin
        data_d = load_word;
        we_d   = 1'b1;
        tmo_d  = '0;
      end
      ST_WRITE: begin
        if (ack_hit) begin
          we_d     = 1'b0;
          strobe_d = 1'b1;
          blk_d    = blk_q - 24'd1;
          // Frame rollover shares the ack update; the block keeps draining into the next frame.
          if (frame_end) begin
            done_d   = 1'b1;
            fcount_d = fcount_q + 32'd1;
            addr_d   = i_base_addr;
            word_d   = '0;
          end else begin
            addr_d = addr_q + INC;
            word_d = word_next;
          end
        end else if (timeout_hit) begin
          we_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      default: ;
    endcase

    if (state_d == ST_RELEASE) act_d = 1'b0;
  end

  always_comb begin
    o_busy           = (state_q != ST_IDLE);
    o_frame_done     = done_q;
    o_frame_count    = fcount_q;
    o_error          = err_q;
    o_rfifo_activate = act_q;
    o_rfifo_strobe   = strobe_q;
    o_mem_we         = we_q;
    o_mem_addr       = addr_q;
    o_mem_data       = data_q;
  end

endmodule

// File: tb/tb_sf_camera_frame_dma.sv
// Scoreboard bench for sf_camera_frame_dma with FIFO and ack-delay memory models.
module tb_sf_camera_frame_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [31:0] i_base_addr;
  logic [23:0] i_frame_words;
  logic        o_busy, o_frame_done, o_error;
  logic [31:0] o_frame_count;
  logic        i_rfifo_ready;
  logic        o_rfifo_activate, o_rfifo_strobe;
  logic [31:0] i_rfifo_data;
  logic [23:0] i_rfifo_size;
  logic        o_mem_we;
  logic [31:0] o_mem_addr, o_mem_data;
  logic        i_mem_ack;

  always #5 clk = ~clk;

  sf_camera_frame_dma #(.ADDR_INC(4), .ACK_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_base_addr(i_base_addr),
    .i_frame_words(i_frame_words), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_frame_count(o_frame_count), .o_error(o_error), .i_rfifo_ready(i_rfifo_ready),
    .o_rfifo_activate(o_rfifo_activate), .o_rfifo_strobe(o_rfifo_strobe),
    .i_rfifo_data(i_rfifo_data), .i_rfifo_size(i_rfifo_size), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .i_mem_ack(i_mem_ack)
  );

  int checks = 0;
  int passed = 0;

  // Stimulus owned by the test tasks.
  logic [31:0] stream [64];
  logic [23:0] blk_size [16];
  int          blk_wr = 0;
  int          ack_delay = 0;
  bit          ack_never = 1'b0;

  // Observation owned by the model process.
  int          sidx = 0, blk_rd = 0, wcnt = 0;
  int          strobe_cnt = 0, done_cnt = 0, act_cycles = 0, we_cycles = 0, hold_err = 0;
  int          obs_n = 0, done_at_obs = 0;
  logic        act_prev = 1'b0;
  logic [31:0] hold_addr = '0, hold_data = '0;
  logic [31:0] obs_addr [1024];
  logic [31:0] obs_data [1024];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  int  obs_rd = 0;

  function automatic logic [31:0] exp_data(input logic [31:0] w);
`ifdef SF_CAMERA_DMA_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // FIFO + memory model, evaluated on the falling edge.
  initial begin
    i_rfifo_ready = 1'b0;
    i_rfifo_size  = '0;
    i_rfifo_data  = '0;
    i_mem_ack     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sidx = 0; blk_rd = 0; wcnt = 0; act_prev = 1'b0;
        i_rfifo_ready = 1'b0; i_mem_ack = 1'b0;
      end else begin
        if (o_rfifo_strobe) begin sidx++; strobe_cnt++; end
        if (o_frame_done) begin done_cnt++; done_at_obs = obs_n; end
        if (o_rfifo_activate) act_cycles++;
        if (o_rfifo_activate && !act_prev) blk_rd++;
        act_prev  = o_rfifo_activate;
        i_mem_ack = 1'b0;
        if (o_mem_we) begin
          we_cycles++;
          if (wcnt == 0) begin
            hold_addr = o_mem_addr; hold_data = o_mem_data;
          end else if (o_mem_addr !== hold_addr || o_mem_data !== hold_data) begin
            hold_err++;
          end
          if (!ack_never && wcnt >= ack_delay) begin
            i_mem_ack = 1'b1;
            if (obs_n < 1024) begin
              obs_addr[obs_n] = o_mem_addr; obs_data[obs_n] = o_mem_data; obs_n++;
            end
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
        end
        i_rfifo_ready = (blk_rd < blk_wr) && !o_rfifo_activate;
        i_rfifo_size  = (blk_rd < 16) ? blk_size[blk_rd] : '0;
        i_rfifo_data  = stream[sidx % 64];
      end
    end
  end

  task automatic do_reset(input int delay, input bit never);
    rst = 1'b1; i_enable = 1'b0; i_frame_words = '0; i_base_addr = '0;
    ack_delay = delay; ack_never = never; blk_wr = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    obs_rd = obs_n;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_block(input logic [23:0] n);
    blk_size[blk_wr] = n;
    blk_wr++;
  endtask

  task automatic wait_obs(input int target, input int budget);
    for (int c = 0; c < budget && (obs_n - obs_rd) < target; c++) @(negedge clk);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_enable = 1'b1; i_frame_words = 24'd8; i_base_addr = 32'h1000;
    blk_wr = 0; ack_delay = 0; ack_never = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({o_busy, o_mem_we, o_rfifo_activate, o_rfifo_strobe, o_frame_done, o_error} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {o_busy, o_mem_we, o_rfifo_activate, o_rfifo_strobe, o_frame_done, o_error});
    else passed++;
    checks++; if (o_mem_addr !== 32'h0 || o_mem_data !== 32'h0)
      $display("FAIL reset_addr_data: got %h/%h want 0/0", o_mem_addr, o_mem_data);
    else passed++;
    checks++; if (o_frame_count !== 32'h0) $display("FAIL reset_count: got %0d want 0", o_frame_count);
    else passed++;
    i_enable = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b0) $display("FAIL idle_disabled: busy got %b want 0", o_busy);
    else passed++;
    i_frame_words = '0; i_enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b0) $display("FAIL idle_zero_frame: busy got %b want 0", o_busy);
    else passed++;
    i_enable = 1'b0;
  endtask

  task automatic test_single_frame();
    int s0, d0, lat;
    wr_t e;
    do_reset(0, 1'b0);
    for (int i = 0; i < 8; i++) stream[i] = $urandom;
    load_block(24'd8);
    repeat (2) @(negedge clk);
    s0 = strobe_cnt; d0 = done_cnt;
    i_base_addr = 32'h1000; i_frame_words = 24'd8;
    for (int i = 0; i < 8; i++) exp_q.push_back('{32'h1000 + 32'(4 * i), exp_data(stream[i])});
    i_enable = 1'b1;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clk);
      if (o_mem_we) break;
    end
    checks++; if (lat !== 4) $display("FAIL first_we_latency: got %0d want 4", lat); else passed++;
    wait_obs(8, 200);
    checks++; if (obs_n - obs_rd !== 8) $display("FAIL single_write_count: got %0d want 8", obs_n - obs_rd);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_addr[obs_rd] !== e.addr || obs_data[obs_rd] !== e.data)
        $display("FAIL single_write: got %h:%h want %h:%h", obs_addr[obs_rd], obs_data[obs_rd], e.addr, e.data);
      else passed++;
      obs_rd++;
    end
    checks++; if (strobe_cnt - s0 !== 8) $display("FAIL single_strobes: got %0d want 8", strobe_cnt - s0); else passed++;
    checks++; if (done_cnt - d0 !== 1) $display("FAIL single_done: got %0d want 1", done_cnt - d0); else passed++;
    checks++; if (o_frame_count !== 32'd1) $display("FAIL single_count: got %0d want 1", o_frame_count); else passed++;
    checks++; if (o_rfifo_activate !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL single_release: act/busy got %b%b want 01", o_rfifo_activate, o_busy);
    else passed++;
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b0) $display("FAIL single_idle: busy got %b want 0", o_busy); else passed++;
  endtask

  task automatic test_carry_over();
    int s0, d0;
    wr_t e;
    do_reset(0, 1'b0);
    for (int i = 0; i < 8; i++) stream[i] = $urandom;
    load_block(24'd4);
    load_block(24'd4);
    repeat (2) @(negedge clk);
    s0 = strobe_cnt; d0 = done_cnt;
    i_base_addr = 32'h1000; i_frame_words = 24'd6;
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{32'h1000 + 32'(4 * ((i < 6) ? i : i - 6)), exp_data(stream[i])});
    i_enable = 1'b1;
    wait_obs(8, 300);
    checks++; if (obs_n - obs_rd !== 8) $display("FAIL carry_write_count: got %0d want 8", obs_n - obs_rd);
    else passed++;
    checks++; if (done_at_obs - obs_rd !== 6) $display("FAIL carry_done_pos: got %0d want 6", done_at_obs - obs_rd);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_addr[obs_rd] !== e.addr || obs_data[obs_rd] !== e.data)
        $display("FAIL carry_write: got %h:%h want %h:%h", obs_addr[obs_rd], obs_data[obs_rd], e.addr, e.data);
      else passed++;
      obs_rd++;
    end
    checks++; if (strobe_cnt - s0 !== 8) $display("FAIL carry_strobes: got %0d want 8", strobe_cnt - s0); else passed++;
    checks++; if (done_cnt - d0 !== 1) $display("FAIL carry_done: got %0d want 1", done_cnt - d0); else passed++;
    checks++; if (o_frame_count !== 32'd1) $display("FAIL carry_count: got %0d want 1", o_frame_count); else passed++;
    i_enable = 1'b0;
  endtask

  task automatic test_zero_block();
    int a0, s0, w0;
    wr_t e;
    do_reset(0, 1'b0);
    load_block(24'd0);
    repeat (2) @(negedge clk);
    a0 = act_cycles; s0 = strobe_cnt; w0 = we_cycles;
    i_base_addr = 32'h2000; i_frame_words = 24'd4;
    i_enable = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (act_cycles - a0 !== 1) $display("FAIL zero_act_cycles: got %0d want 1", act_cycles - a0); else passed++;
    checks++; if (strobe_cnt - s0 !== 0 || we_cycles - w0 !== 0)
      $display("FAIL zero_no_traffic: strobes %0d we %0d want 0 0", strobe_cnt - s0, we_cycles - w0);
    else passed++;
    checks++; if (o_busy !== 1'b1 || o_rfifo_activate !== 1'b0)
      $display("FAIL zero_wait_blk: busy/act got %b%b want 10", o_busy, o_rfifo_activate);
    else passed++;
    stream[0] = $urandom; stream[1] = $urandom;
    exp_q.push_back('{32'h2000, exp_data(stream[0])});
    exp_q.push_back('{32'h2004, exp_data(stream[1])});
    load_block(24'd2);
    wait_obs(2, 100);
    checks++; if (obs_n - obs_rd !== 2) $display("FAIL zero_follow_count: got %0d want 2", obs_n - obs_rd);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_addr[obs_rd] !== e.addr || obs_data[obs_rd] !== e.data)
        $display("FAIL zero_follow_write: got %h:%h want %h:%h", obs_addr[obs_rd], obs_data[obs_rd], e.addr, e.data);
      else passed++;
      obs_rd++;
    end
    checks++; if (o_frame_count !== 32'd0) $display("FAIL zero_count: got %0d want 0", o_frame_count); else passed++;
    i_enable = 1'b0;
  endtask

  task automatic test_ack_delay();
    int s0, d0, w0, h0;
    wr_t e;
    do_reset(5, 1'b0);
    for (int i = 0; i < 4; i++) stream[i] = $urandom;
    load_block(24'd4);
    repeat (2) @(negedge clk);
    s0 = strobe_cnt; d0 = done_cnt; w0 = we_cycles; h0 = hold_err;
    i_base_addr = 32'h3000; i_frame_words = 24'd4;
    for (int i = 0; i < 4; i++) exp_q.push_back('{32'h3000 + 32'(4 * i), exp_data(stream[i])});
    i_enable = 1'b1;
    wait_obs(4, 300);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_addr[obs_rd] !== e.addr || obs_data[obs_rd] !== e.data)
        $display("FAIL delay_write: got %h:%h want %h:%h", obs_addr[obs_rd], obs_data[obs_rd], e.addr, e.data);
      else passed++;
      obs_rd++;
    end
    checks++; if (we_cycles - w0 !== 24) $display("FAIL delay_we_cycles: got %0d want 24", we_cycles - w0); else passed++;
    checks++; if (hold_err - h0 !== 0) $display("FAIL delay_hold_stable: got %0d changes want 0", hold_err - h0); else passed++;
    checks++; if (strobe_cnt - s0 !== 4) $display("FAIL delay_strobes: got %0d want 4", strobe_cnt - s0); else passed++;
    checks++; if (done_cnt - d0 !== 1) $display("FAIL delay_done: got %0d want 1", done_cnt - d0); else passed++;
    i_enable = 1'b0;
  endtask

  task automatic test_timeout();
    int s0, w0, o0;
    do_reset(0, 1'b1);
    for (int i = 0; i < 4; i++) stream[i] = $urandom;
    load_block(24'd4);
    repeat (2) @(negedge clk);
    s0 = strobe_cnt; w0 = we_cycles; o0 = obs_n;
    i_base_addr = 32'h4000; i_frame_words = 24'd4;
    i_enable = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (o_error !== 1'b0) $display("FAIL timeout_early: error got %b want 0", o_error); else passed++;
    for (int c = 0; c < 200 && !o_error; c++) @(negedge clk);
    checks++; if (o_error !== 1'b1) $display("FAIL timeout_error: got %b want 1", o_error); else passed++;
    checks++; if (we_cycles - w0 !== 256) $display("FAIL timeout_we_cycles: got %0d want 256", we_cycles - w0); else passed++;
    checks++; if (o_mem_we !== 1'b0 || o_rfifo_activate !== 1'b0)
      $display("FAIL timeout_release: we/act got %b%b want 00", o_mem_we, o_rfifo_activate);
    else passed++;
    checks++; if (o_frame_count !== 32'd0 || strobe_cnt - s0 !== 0 || obs_n - o0 !== 0)
      $display("FAIL timeout_no_progress: count %0d strobes %0d writes %0d want 0 0 0",
               o_frame_count, strobe_cnt - s0, obs_n - o0);
    else passed++;
    repeat (5) @(negedge clk);
    checks++; if (o_error !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", o_error); else passed++;
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_error !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL timeout_clear: error/busy got %b%b want 00", o_error, o_busy);
    else passed++;
  endtask

  task automatic test_disable_mid_block();
    int s0, d0;
    wr_t e;
    do_reset(3, 1'b0);
    for (int i = 0; i < 8; i++) stream[i] = $urandom;
    stream[2] = 32'h11223344;
    load_block(24'd8);
    repeat (2) @(negedge clk);
    s0 = strobe_cnt; d0 = done_cnt;
    i_base_addr = 32'h5000; i_frame_words = 24'd8;
    for (int i = 0; i < 3; i++) exp_q.push_back('{32'h5000 + 32'(4 * i), exp_data(stream[i])});
    i_enable = 1'b1;
    for (int c = 0; c < 200 && (obs_n - obs_rd) < 2; c++) @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 50 && !o_mem_we; c++) @(negedge clk);
    i_enable = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (obs_n - obs_rd !== 3) $display("FAIL disable_write_count: got %0d want 3", obs_n - obs_rd);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_addr[obs_rd] !== e.addr || obs_data[obs_rd] !== e.data)
        $display("FAIL disable_write: got %h:%h want %h:%h", obs_addr[obs_rd], obs_data[obs_rd], e.addr, e.data);
      else passed++;
      obs_rd++;
    end
    checks++; if (strobe_cnt - s0 !== 3) $display("FAIL disable_strobes: got %0d want 3", strobe_cnt - s0); else passed++;
    checks++; if (done_cnt - d0 !== 0 || o_frame_count !== 32'd0)
      $display("FAIL disable_no_frame: done %0d count %0d want 0 0", done_cnt - d0, o_frame_count);
    else passed++;
    checks++; if (o_rfifo_activate !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL disable_idle: act/busy got %b%b want 00", o_rfifo_activate, o_busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_carry_over();
    test_zero_block();
    test_ack_delay();
    test_timeout();
    test_disable_mid_block();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d passed", passed, checks);
    $fatal(1);
  end

endmodule
